onp_eval_param: RTL and testbench
=================================

Name: onp_eval_param

Overview:
Parametrised reverse-Polish (ONP) expression evaluator, the successor to the fixed 32-bit M1_ONP calculator. It accepts a token stream of operands and operators over a strobe/ack/busy handshake and keeps operands on an internal stack of configurable depth. On the '=' token it emits the result with an error code. Generalisations over M1_ONP: a separate operand/operator flag (full-range operands), signed multi-cycle division, and sticky error reporting with stack-level visibility.

Parameters:
DW, 32, data/operand width in bits (signed two's complement)
DEPTH, 16, stack entries (>=2)
LW, $clog2(DEPTH+1), width of stack-level counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
I_DAT  in  DW  token: operand value, or operator ASCII code in bits [7:0]
I_OP  in  1  1 = I_DAT is an operator, 0 = operand
I_STB  in  1  token valid
I_ACK  out  1  token accepted this cycle; combinational I_STB & ~I_BSY
I_BSY  out  1  registered; evaluator cannot accept a token
O_DAT  out  DW  result
O_ERR  out  3  result status code
O_STB  out  1  result valid; held until O_ACK
O_ACK  in  1  result consumed
STK_LVL  out  LW  current stack occupancy

Behaviour:
- Reset (RST=0, async): state IDLE, stack empty, I_BSY=0, O_STB=0, O_DAT=0, O_ERR=0, STK_LVL=0, error flag cleared.
- Transfer: a token is taken in the cycle where I_STB=1 and I_BSY=0.
- States: IDLE, EXEC, DIV, OUT.
- Operand in IDLE:
  - Push if STK_LVL<DEPTH. I_BSY stays 0, so back-to-back operands run one per cycle.
  - If the stack is full: drop the operand and set error 2.
- Operators: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F, '=' 0x3D.
  - Operand order: b = top, a = next; result = a op b. Pop two, push one.
- '+', '-', '*': IDLE -> EXEC. I_BSY=1 for exactly one cycle; result written at the end of EXEC.
  - Results wrap modulo 2^DW; '*' keeps the low DW bits.
- '/': IDLE -> DIV. Signed restoring divide on magnitudes, quotient truncated toward zero.
  - I_BSY=1 for exactly DW+1 cycles.
  - MIN/-1 returns MIN (wrap).
  - b=0: result not pushed, stack pops both operands, error 3, no iteration (1 busy cycle).
- Operator with STK_LVL<2: stack unchanged, error 1, I_BSY=1 for one cycle.
- Unknown operator code: stack unchanged, error 4.
- Error flag is sticky: the first code is kept. While set, operand and operator tokens are accepted and discarded with I_BSY=0; only '=' is acted on.
- '=' -> OUT, I_BSY=1, O_STB=1 on the next cycle.
  - No error and STK_LVL=1: O_DAT=top, O_ERR=0.
  - STK_LVL=0: O_ERR=1, O_DAT=0.
  - STK_LVL>1: O_ERR=5, O_DAT=top.
  - Any stored error: O_ERR=stored code, O_DAT=0.
- O_STB, O_DAT and O_ERR are held stable until a cycle with O_ACK=1 and O_STB=1. Next cycle: O_STB=0, stack emptied, error cleared, state IDLE, I_BSY=0.
- O_ACK while O_STB=0 is ignored.
- I_STB while busy is not a transfer; the source holds the token.
- Reset mid-division or mid-OUT aborts immediately; the pending result is lost.

Test Plan:
1. Reset, then tokens 3, 4, '+', 2, '*', '=' -> O_STB=1, O_DAT=14, O_ERR=0; after O_ACK, STK_LVL=0 and I_BSY=0.
2. -7, 2, '/', '=' -> I_BSY high DW+1 cycles during '/'; O_DAT=-3, O_ERR=0. Also MIN, -1, '/' -> O_DAT=MIN.
3. 5, 0, '/', 1, '+', '=' -> O_ERR=3, O_DAT=0. Tokens after the error are accepted with I_BSY=0.
4. DEPTH+1 operands then '=' -> O_ERR=2. Then '+' on an empty stack, '=' -> O_ERR=1.
5. 1, 2, '=' -> O_ERR=5, O_DAT=2. Also operator 0x25 -> O_ERR=4.
6. Hold O_ACK=0 for 10 cycles with I_STB=1 -> O_STB/O_DAT stable and no token taken. Assert RST=0 mid-'/' -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/onp_eval_param.sv
// Reverse-Polish expression evaluator: stacks operands and applies + - * / on a
// strobe/ack/busy token stream. The '=' token emits the result with a status code.
module onp_eval_param #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] I_DAT,
    input  logic          I_OP,
    input  logic          I_STB,
    output logic          I_ACK,
    output logic          I_BSY,
    output logic [DW-1:0] O_DAT,
    output logic [2:0]    O_ERR,
    output logic          O_STB,
    input  logic          O_ACK,
    output logic [LW-1:0] STK_LVL
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DW + 1);

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;
    localparam logic [7:0] OP_EQ  = 8'h3D;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_UNDER = 3'd1;
    localparam logic [2:0] E_FULL  = 3'd2;
    localparam logic [2:0] E_DIV0  = 3'd3;
    localparam logic [2:0] E_BADOP = 3'd4;
    localparam logic [2:0] E_LEFT  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_OUT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] stk_q [DEPTH];
    logic [DW-1:0] stk_d [DEPTH];
    logic [LW-1:0] lvl_q, lvl_d;
    logic [2:0]    err_q, err_d;
    logic          bsy_q, bsy_d;
    logic          ostb_q, ostb_d;
    logic [DW-1:0] odat_q, odat_d;
    logic [2:0]    oerr_q, oerr_d;
    logic [7:0]    opc_q, opc_d;
    logic [DW:0]   rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          take_c;
    logic [7:0]    opc_in_c;
    logic          known_c;
    logic [IW-1:0] push_idx_c, top_idx_c, nxt_idx_c;
    logic [DW-1:0] top_c, nxt_c, alu_c, quo_res_c;
    logic [DW:0]   rem_sh_c, diff_c;

    assign take_c     = I_STB & ~bsy_q;
    assign I_ACK      = take_c;
    assign opc_in_c   = I_DAT[7:0];
    assign known_c    = (opc_in_c == OP_ADD) || (opc_in_c == OP_SUB) ||
                        (opc_in_c == OP_MUL) || (opc_in_c == OP_DIV);
    assign push_idx_c = IW'(lvl_q);
    assign top_idx_c  = IW'(lvl_q - LW'(1));
    assign nxt_idx_c  = IW'(lvl_q - LW'(2));
    assign top_c      = stk_q[top_idx_c];
    assign nxt_c      = stk_q[nxt_idx_c];

    // Restoring-divide step on magnitudes; diff_c[DW] set means the trial subtract borrowed
    assign rem_sh_c  = {rem_q[DW-1:0], quo_q[DW-1]};
    assign diff_c    = rem_sh_c - {1'b0, dvs_q};
    assign quo_res_c = neg_q ? (~quo_q + DW'(1)) : quo_q;

    always_comb begin
        unique case (opc_q)
            OP_SUB:  alu_c = nxt_c - top_c;
            OP_MUL:  alu_c = nxt_c * top_c;
            default: alu_c = nxt_c + top_c;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stk_d   = stk_q;
        lvl_d   = lvl_q;
        err_d   = err_q;
        bsy_d   = bsy_q;
        ostb_d  = ostb_q;
        odat_d  = odat_q;
        oerr_d  = oerr_q;
        opc_d   = opc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                bsy_d = 1'b0;
                if (take_c) begin
                    if (I_OP && (opc_in_c == OP_EQ)) begin
                        state_d = S_OUT;
                        bsy_d   = 1'b1;
                        ostb_d  = 1'b1;
                        if (err_q != E_NONE) begin
                            oerr_d = err_q;
                            odat_d = '0;
                        end else if (lvl_q == LW'(0)) begin
                            oerr_d = E_UNDER;
                            odat_d = '0;
                        end else if (lvl_q > LW'(1)) begin
                            oerr_d = E_LEFT;
                            odat_d = top_c;
                        end else begin
                            oerr_d = E_NONE;
                            odat_d = top_c;
                        end
                    end else if (err_q == E_NONE) begin
                        // Sticky error: everything but '=' is silently consumed
                        if (!I_OP) begin
                            if (lvl_q == LW'(DEPTH)) begin
                                err_d = E_FULL;
                            end else begin
                                stk_d[push_idx_c] = I_DAT;
                                lvl_d             = lvl_q + LW'(1);
                            end
                        end else if (!known_c) begin
                            err_d = E_BADOP;
                        end else if (lvl_q < LW'(2)) begin
                            err_d = E_UNDER;
                            bsy_d = 1'b1;
                        end else if (opc_in_c == OP_DIV) begin
                            bsy_d = 1'b1;
                            if (top_c == '0) begin
                                err_d = E_DIV0;
                                lvl_d = lvl_q - LW'(2);
                            end else begin
                                state_d = S_DIV;
                                rem_d   = '0;
                                quo_d   = nxt_c[DW-1] ? (~nxt_c + DW'(1)) : nxt_c;
                                dvs_d   = top_c[DW-1] ? (~top_c + DW'(1)) : top_c;
                                neg_d   = nxt_c[DW-1] ^ top_c[DW-1];
                                cnt_d   = '0;
                            end
                        end else begin
                            state_d = S_EXEC;
                            bsy_d   = 1'b1;
                            opc_d   = opc_in_c;
                        end
                    end
                end
            end
            S_EXEC: begin
                stk_d[nxt_idx_c] = alu_c;
                lvl_d            = lvl_q - LW'(1);
                bsy_d            = 1'b0;
                state_d          = S_IDLE;
            end
            S_DIV: begin
                // DW shift/subtract steps, then one cycle to apply the sign and write back
                if (cnt_q == CW'(DW)) begin
                    stk_d[nxt_idx_c] = quo_res_c;
                    lvl_d            = lvl_q - LW'(1);
                    bsy_d            = 1'b0;
                    state_d          = S_IDLE;
                end else begin
                    if (!diff_c[DW]) begin
                        rem_d = diff_c;
                        quo_d = {quo_q[DW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh_c;
                        quo_d = {quo_q[DW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (O_ACK && ostb_q) begin
                    ostb_d  = 1'b0;
                    lvl_d   = '0;
                    err_d   = E_NONE;
                    bsy_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            for (int i = 0; i < int'(DEPTH); i++) stk_q[i] <= '0;
            lvl_q   <= '0;
            err_q   <= E_NONE;
            bsy_q   <= 1'b0;
            ostb_q  <= 1'b0;
            odat_q  <= '0;
            oerr_q  <= E_NONE;
            opc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stk_q   <= stk_d;
            lvl_q   <= lvl_d;
            err_q   <= err_d;
            bsy_q   <= bsy_d;
            ostb_q  <= ostb_d;
            odat_q  <= odat_d;
            oerr_q  <= oerr_d;
            opc_q   <= opc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign I_BSY   = bsy_q;
    assign O_STB   = ostb_q;
    assign O_DAT   = odat_q;
    assign O_ERR   = oerr_q;
    assign STK_LVL = lvl_q;

endmodule

// File: tb/tb_onp_eval_param.sv
// Bench for onp_eval_param: table of RPN expressions with expected results and busy
// lengths, a result scoreboard queue, plus output-hold and async-reset sequences.
module tb_onp_eval_param;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam logic [7:0] NOCHK = 8'hFF;

    logic          CLK, RST;
    logic [DW-1:0] I_DAT;
    logic          I_OP, I_STB, I_ACK, I_BSY;
    logic [DW-1:0] O_DAT;
    logic [2:0]    O_ERR;
    logic          O_STB, O_ACK;
    logic [LW-1:0] STK_LVL;

    onp_eval_param #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .I_DAT(I_DAT), .I_OP(I_OP), .I_STB(I_STB),
        .I_ACK(I_ACK), .I_BSY(I_BSY), .O_DAT(O_DAT), .O_ERR(O_ERR),
        .O_STB(O_STB), .O_ACK(O_ACK), .STK_LVL(STK_LVL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]          n;
        logic [7:0]          op;
        logic [7:0][7:0]     bsy;
        logic [7:0][DW-1:0]  dat;
        logic [DW-1:0]       edat;
        logic [2:0]          eerr;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [2:0]    e;
    } exp_t;

    vec_t vecs [16];
    int   nv;
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic opd(input logic [DW-1:0] d);
        logic [2:0] k;
        k = vecs[nv].n[2:0];
        vecs[nv].dat[k] = d;
        vecs[nv].op[k]  = 1'b0;
        vecs[nv].bsy[k] = 8'd0;
        vecs[nv].n      = vecs[nv].n + 4'd1;
    endtask

    task automatic opr(input logic [7:0] c, input logic [7:0] b);
        logic [2:0] k;
        k = vecs[nv].n[2:0];
        vecs[nv].dat[k] = DW'(c);
        vecs[nv].op[k]  = 1'b1;
        vecs[nv].bsy[k] = b;
        vecs[nv].n      = vecs[nv].n + 4'd1;
    endtask

    task automatic fin(input logic [DW-1:0] d, input logic [2:0] e);
        opr(8'h3D, NOCHK);
        vecs[nv].edat = d;
        vecs[nv].eerr = e;
        nv++;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer edge
    task automatic send_tok(input logic [DW-1:0] d, input logic op);
        int w;
        I_DAT = d;
        I_OP  = op;
        I_STB = 1'b1;
        w     = 0;
        #1;
        while (!I_ACK && w < 200) begin
            @(negedge CLK);
            #1;
            w++;
        end
        if (!I_ACK) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: token %0h not accepted after %0d cycles", d, w);
            I_STB = 1'b0;
        end else begin
            @(negedge CLK);
            I_STB = 1'b0;
        end
    endtask

    task automatic busy_len(input logic [7:0] exp_len);
        int c;
        c = 0;
        while (I_BSY && c < 100) begin
            c++;
            @(negedge CLK);
        end
        chk("busy_cycles", 64'(c), 64'(exp_len));
    endtask

    task automatic get_result();
        int   w;
        exp_t e;
        w = 0;
        while (!O_STB && w < 200) begin
            @(negedge CLK);
            w++;
        end
        chk("o_stb_seen", 64'(O_STB), 64'(1'b1));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: result with empty queue, got dat %0h err %0d", O_DAT, O_ERR);
        end else begin
            e = sb.pop_front();
            chk("o_dat", 64'(O_DAT), 64'(e.d));
            chk("o_err", 64'(O_ERR), 64'(e.e));
        end
        O_ACK = 1'b1;
        @(negedge CLK);
        O_ACK = 1'b0;
        chk("o_stb_after_ack", 64'(O_STB), 64'(1'b0));
        chk("lvl_after_ack", 64'(STK_LVL), 64'(0));
        chk("bsy_after_ack", 64'(I_BSY), 64'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t he;
        RST = 1'b0; I_DAT = '0; I_OP = 1'b0; I_STB = 1'b0; O_ACK = 1'b0;
        for (int i = 0; i < 16; i++) vecs[i] = '0;
        nv = 0;

        opd(3); opd(4); opr(8'h2B, 1); opd(2); opr(8'h2A, 1); fin(32'd14, 3'd0);
        opd(-32'sd7); opd(2); opr(8'h2F, 33); fin(32'hFFFF_FFFD, 3'd0);
        opd(32'h8000_0000); opd(32'hFFFF_FFFF); opr(8'h2F, 33); fin(32'h8000_0000, 3'd0);
        opd(5); opd(0); opr(8'h2F, 1); opd(1); opr(8'h2B, 0); fin(32'd0, 3'd3);
        opd(1); opd(2); fin(32'd2, 3'd5);
        opd(1); opd(2); opr(8'h25, NOCHK); fin(32'd0, 3'd4);
        opd(1); opd(2); opd(3); opd(4); opd(5); fin(32'd0, 3'd2);
        opr(8'h2B, 1); fin(32'd0, 3'd1);
        fin(32'd0, 3'd1);
        opd(10); opd(3); opr(8'h2D, 1); fin(32'd7, 3'd0);
        opd(100); opd(-32'sd7); opr(8'h2F, 33); fin(32'hFFFF_FFF2, 3'd0);
        opd(32'h7FFF_FFFF); opd(1); opr(8'h2B, 1); fin(32'h8000_0000, 3'd0);
        opd(32'h0001_0000); opd(32'h0001_0000); opr(8'h2A, 1); fin(32'd0, 3'd0);
        opd(1); opr(8'h2B, 1); fin(32'd0, 3'd1);
        opd(-32'sd6); opd(-32'sd3); opr(8'h2F, 33); fin(32'd2, 3'd0);
        opd(3); opd(1); opd(2); opr(8'h2D, 1); opr(8'h2A, 1); fin(32'hFFFF_FFFD, 3'd0);

        repeat (3) @(negedge CLK);
        chk("rst_bsy", 64'(I_BSY), 64'(1'b0));
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_ostb", 64'(O_STB), 64'(1'b0));
        chk("rst_odat", 64'(O_DAT), 64'(0));
        chk("rst_oerr", 64'(O_ERR), 64'(0));
        chk("rst_lvl", 64'(STK_LVL), 64'(0));
        chk("rst_ack_idle", 64'(I_ACK), 64'(1'b0));

        for (int v = 0; v < nv; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                send_tok(vecs[v].dat[k], vecs[v].op[k]);
                if (vecs[v].op[k] && vecs[v].dat[k][7:0] == 8'h3D) begin
                    he.d = vecs[v].edat;
                    he.e = vecs[v].eerr;
                    sb.push_back(he);
                end else if (vecs[v].bsy[k] != NOCHK) begin
                    busy_len(vecs[v].bsy[k]);
                end
            end
            get_result();
        end

        // Result must hold while O_ACK is low, and a waiting token must not be taken
        send_tok(6, 1'b0);
        send_tok(7, 1'b0);
        send_tok(DW'(8'h2A), 1'b1);
        busy_len(1);
        send_tok(DW'(8'h3D), 1'b1);
        he.d = 32'd42;
        he.e = 3'd0;
        sb.push_back(he);
        @(negedge CLK);
        I_DAT = 9; I_OP = 1'b0; I_STB = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("hold_ostb", 64'(O_STB), 64'(1'b1));
            chk("hold_odat", 64'(O_DAT), 64'(42));
            chk("hold_no_ack", 64'(I_ACK), 64'(1'b0));
        end
        chk("hold_lvl", 64'(STK_LVL), 64'(1));
        I_STB = 1'b0;
        get_result();

        // Asynchronous reset in the middle of a division
        send_tok(7, 1'b0);
        send_tok(2, 1'b0);
        send_tok(DW'(8'h2F), 1'b1);
        repeat (5) @(negedge CLK);
        chk("div_busy_mid", 64'(I_BSY), 64'(1'b1));
        #3 RST = 1'b0;
        #1;
        chk("arst_bsy", 64'(I_BSY), 64'(1'b0));
        chk("arst_ostb", 64'(O_STB), 64'(1'b0));
        chk("arst_odat", 64'(O_DAT), 64'(0));
        chk("arst_oerr", 64'(O_ERR), 64'(0));
        chk("arst_lvl", 64'(STK_LVL), 64'(0));
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        send_tok(8, 1'b0);
        send_tok(2, 1'b0);
        send_tok(DW'(8'h2F), 1'b1);
        busy_len(33);
        send_tok(DW'(8'h3D), 1'b1);
        he.d = 32'd4;
        he.e = 3'd0;
        sb.push_back(he);
        get_result();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
